// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if
//   Load/store port between a requester (the core's LSU or a bench) and a
//   data-memory responder. One request is in flight at a time.
//
//   Request  (master -> slave): req_valid, req_we, req_addr, req_wdata,
//                               req_size, req_unsigned
//   Request  (slave -> master): req_ready
//   Response (slave -> master): rsp_valid, rsp_rdata, rsp_err
// ----------------------------------------------------------------------------
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the core's load/store port. It accepts one
//   request, waits WAIT_CYCLES cycles, then performs a little-endian
//   byte/half/word access. The result comes back as a one-cycle response.
//
//   Parameters:
//     DEPTH_LOG2   memory depth = 2**DEPTH_LOG2 32-bit words
//     WAIT_CYCLES  wait states between acceptance and response (0..15)
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   dmem_if.slave: req_* handshake in, req_ready and rsp_* out
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    // Copies of the accepted request.
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [1:0]  l_size;
    logic        l_unsigned;

    logic [31:0] mem [DEPTH];

    // With zero wait states the access happens on the accepting edge. At that
    // point the latched copies are not yet loaded, so in IDLE the live request
    // supplies the access. In all other states the latched copy is used.
    logic                  accept;
    logic                  enter_resp;
    logic                  a_we;
    logic [31:0]           a_addr;
    logic [31:0]           a_wdata;
    logic [1:0]            a_size;
    logic                  a_unsigned;
    logic                  a_err;
    logic [DEPTH_LOG2-1:0] widx;
    logic [31:0]           rword;
    logic [31:0]           shifted;
    logic [31:0]           load_data;
    logic [3:0]            be;
    logic [31:0]           wd;

    assign accept     = bus.req_valid & ready_q;
    assign enter_resp = ((state == ST_WAIT) && (cnt == 4'd0)) ||
                        ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0));

    assign a_we       = (state == ST_IDLE) ? bus.req_we       : l_we;
    assign a_addr     = (state == ST_IDLE) ? bus.req_addr     : l_addr;
    assign a_wdata    = (state == ST_IDLE) ? bus.req_wdata    : l_wdata;
    assign a_size     = (state == ST_IDLE) ? bus.req_size     : l_size;
    assign a_unsigned = (state == ST_IDLE) ? bus.req_unsigned : l_unsigned;

    assign widx    = a_addr[DEPTH_LOG2+1:2];
    assign rword   = mem[widx];
    assign shifted = rword >> {a_addr[1:0], 3'b000};

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        a_err     = 1'b0;
        load_data = rword;
        be        = 4'b1111;
        wd        = a_wdata;
        case (a_size)
            2'b00: begin
                load_data = a_unsigned ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
                be        = 4'b0001 << a_addr[1:0];
                wd        = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                a_err     = a_addr[0];
                load_data = a_unsigned ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
                be        = 4'b0011 << {a_addr[1], 1'b0};
                wd        = {2{a_wdata[15:0]}};
            end
            2'b10:   a_err = (a_addr[1:0] != 2'b00);
            default: a_err = 1'b1;
        endcase
        if (a_addr[31:DEPTH_LOG2+2] != '0) a_err = 1'b1;
    end

    // NOTE: the memory array has no reset. Clearing it is not part of the
    // behaviour. A reset branch would also stop it from mapping onto RAM.
    always_ff @(posedge clk) begin
        if (enter_resp && a_we && !a_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            l_we        <= 1'b0;
            l_addr      <= 32'd0;
            l_wdata     <= 32'd0;
            l_size      <= 2'b00;
            l_unsigned  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        l_we       <= bus.req_we;
                        l_addr     <= bus.req_addr;
                        l_wdata    <= bus.req_wdata;
                        l_size     <= bus.req_size;
                        l_unsigned <= bus.req_unsigned;
                        ready_q    <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= (a_we || a_err) ? 32'd0 : load_data;
                            rsp_err_q   <= a_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (a_we || a_err) ? 32'd0 : load_data;
                        rsp_err_q   <= a_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
